gerenciador_atributos: RTL and testbench

Parametrised successor to the pet's fixed three-attribute controller. It holds NUM_ATTR saturating attribute counters, each WIDTH bits, for example hunger, happiness and sleep. Every counter decays on a divided "life tick" and recovers on per-channel action pulses. It flags low-level alarms and raises a sticky death flag when any attribute stays empty too long. It sits between the state controller (source of actions and pause) and the image/display path (consumer of values and alarms).

---
 rtl/gerenciador_atributos_pkg.sv | 16 +
 rtl/gerenciador_atributos_divisor_tick.sv | 34 +++
 rtl/gerenciador_atributos.sv | 98 +++++++++
 tb/tb_gerenciador_atributos.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gerenciador_atributos_pkg.sv
// Shared definitions for the pet attribute manager: channel indices and
// default widths/thresholds also used by the state and image controllers.
package gerenciador_atributos_pkg;

    localparam int ATR_FOME       = 0;
    localparam int ATR_FELICIDADE = 1;
    localparam int ATR_SONO       = 2;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LIMIAR = 64;

    function automatic int valor_maximo(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/gerenciador_atributos_divisor_tick.sv
// Life-tick divider: emits a registered one-cycle strobe every TICK_DIV
// enabled cycles and holds its partial count while disabled.
module divisor_tick #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

    logic [CW-1:0] contagem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (contagem == ULTIMO) begin
                    contagem <= '0;
                    tick     <= 1'b1;
                end else begin
                    contagem <= contagem + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gerenciador_atributos.sv
// Parametrised attribute manager: NUM_ATTR saturating counters that decay on
// the life tick, recover on action pulses, raise alarms and a sticky death flag.
module gerenciador_atributos
    import gerenciador_atributos_pkg::*;
#(
    parameter int NUM_ATTR    = 3,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TICK_DIV    = 50000000,
    parameter int DECAY       = 1,
    parameter int GAIN        = 32,
    parameter int INIT        = valor_maximo(WIDTH),
    parameter int LIMIAR      = DEF_LIMIAR,
    parameter int GRACE_TICKS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pausa,
    input  logic [NUM_ATTR-1:0]       acao,
    output logic [NUM_ATTR*WIDTH-1:0] valores,
    output logic [NUM_ATTR-1:0]       alarme,
    output logic                      tick,
    output logic                      morreu
);

    localparam int EW = $clog2(GRACE_TICKS + 1);
    localparam logic [WIDTH:0]   MAX_V    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   DECAY_W  = (WIDTH + 1)'(DECAY);
    localparam logic [WIDTH:0]   GAIN_W   = (WIDTH + 1)'(GAIN);
    localparam logic [WIDTH:0]   LIMIAR_W = (WIDTH + 1)'(LIMIAR);
    localparam logic [EW-1:0]    GRACE_W  = EW'(GRACE_TICKS);
    localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT);

    logic                tick_en;
    logic                decay_en;
    logic [NUM_ATTR-1:0] morte_req;

    assign tick_en  = !pausa && !morreu;
    // A tick already in flight when pausa rises must not decay anything.
    assign decay_en = tick && !pausa;

    divisor_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_divisor (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    for (genvar i = 0; i < NUM_ATTR; i++) begin : g_canal
        logic [WIDTH-1:0] valor;
        logic [WIDTH-1:0] proximo;
        logic [WIDTH:0]   decaido;
        logic [WIDTH:0]   soma;
        logic [EW-1:0]    vazio;

        // Decay first, then gain, both in a WIDTH+1 bit intermediate.
        always_comb begin
            decaido = {1'b0, valor};
            if (decay_en) begin
                decaido = (decaido >= DECAY_W) ? (decaido - DECAY_W) : '0;
            end
            soma    = decaido + GAIN_W;
            proximo = decaido[WIDTH-1:0];
            if (acao[i]) begin
                proximo = (soma > MAX_V) ? MAX_V[WIDTH-1:0] : soma[WIDTH-1:0];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valor <= INIT_W;
                vazio <= '0;
            end else if (!morreu) begin
                valor <= proximo;
                if (valor != '0 || acao[i]) begin
                    vazio <= '0;
                end else if (decay_en) begin
                    vazio <= vazio + EW'(1);
                end
            end
        end

        assign morte_req[i] = !morreu && decay_en && (valor == '0) && !acao[i]
                              && ((vazio + EW'(1)) == GRACE_W);
        assign alarme[i] = ({1'b0, valor} < LIMIAR_W);
        assign valores[i*WIDTH +: WIDTH] = valor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            morreu <= 1'b0;
        end else if (|morte_req) begin
            morreu <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Scoreboard bench for gerenciador_atributos: a behavioural model queues the
// expected outputs for every driven cycle and they are popped after each edge.
module tb_gerenciador_atributos;
    import gerenciador_atributos_pkg::*;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int TD  = 4;
    localparam int DEC = 1;
    localparam int GN  = 16;
    localparam int INI = 255;
    localparam int LIM = 64;
    localparam int GR  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           pausa;
    logic [N-1:0]   acao;
    logic [N*W-1:0] valores;
    logic [N-1:0]   alarme;
    logic           tick;
    logic           morreu;

    always #5 clk = ~clk;

    gerenciador_atributos #(
        .NUM_ATTR(N), .WIDTH(W), .TICK_DIV(TD), .DECAY(DEC), .GAIN(GN),
        .INIT(INI), .LIMIAR(LIM), .GRACE_TICKS(GR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pausa  (pausa),
        .acao   (acao),
        .valores(valores),
        .alarme (alarme),
        .tick   (tick),
        .morreu (morreu)
    );

    typedef struct packed {
        logic [N*W-1:0] valores;
        logic [N-1:0]   alarme;
        logic           tick;
        logic           morreu;
    } amostra_t;

    amostra_t fila[$];
    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    int m_v[N];
    int m_empty[N];
    int m_cnt;
    bit m_tick;
    bit m_dead;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ch(input int i);
        return int'(valores[i*W +: W]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i]     = INI;
            m_empty[i] = 0;
        end
        m_cnt  = 0;
        m_tick = 1'b0;
        m_dead = 1'b0;
        fila.delete();
    endtask

    task automatic model_step(input bit p, input logic [N-1:0] a);
        bit dec_en;
        bit die;
        int nv[N];
        dec_en = m_tick && !p;
        die    = 1'b0;
        for (int i = 0; i < N; i++) begin
            int d;
            nv[i] = m_v[i];
            if (!m_dead) begin
                d = m_v[i];
                if (dec_en) d = (d - DEC < 0) ? 0 : d - DEC;
                if (a[i])   d = (d + GN > 255) ? 255 : d + GN;
                nv[i] = d;
                if (m_v[i] != 0 || a[i]) begin
                    m_empty[i] = 0;
                end else if (dec_en) begin
                    m_empty[i]++;
                    if (m_empty[i] == GR) die = 1'b1;
                end
            end
        end
        if (!p && !m_dead) begin
            if (m_cnt == TD - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
            end else begin
                m_cnt++;
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        for (int i = 0; i < N; i++) m_v[i] = nv[i];
        if (die) m_dead = 1'b1;
    endtask

    function automatic amostra_t model_expected();
        amostra_t e;
        for (int i = 0; i < N; i++) begin
            e.valores[i*W +: W] = W'(m_v[i]);
            e.alarme[i]         = (m_v[i] < LIM);
        end
        e.tick   = m_tick;
        e.morreu = m_dead;
        return e;
    endfunction

    task automatic apply_stimulus(input bit p, input logic [N-1:0] a);
        amostra_t e;
        pausa = p;
        acao  = a;
        model_step(p, a);
        fila.push_back(model_expected());
        @(posedge clk);
        #1;
        e = fila.pop_front();
        check_output("valores", valores, e.valores);
        check_output("alarme", alarme, e.alarme);
        check_output("tick", tick, e.tick);
        check_output("morreu", morreu, e.morreu);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        pausa = 1'b0;
        acao  = '0;
        #1;
        model_reset();
        check_output("reset_valores", valores, {N{8'hFF}});
        check_output("reset_alarme", alarme, 0);
        check_output("reset_tick", tick, 0);
        check_output("reset_morreu", morreu, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Keeps the other two channels topped up so only channel 0 can empty.
    task automatic keep_step();
        apply_stimulus(1'b0, (cyc % 32 == 0) ? 3'b110 : 3'b000);
        cyc++;
    endtask

    task automatic wait_empty_ticks(input int k);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < k && guard < 3000) begin
            keep_step();
            if (tick && ch(ATR_FOME) == 0) seen++;
            guard++;
        end
        if (seen < k) check_output("timeout_vazio", 0, 1);
        keep_step();
    endtask

    initial begin
        int guard;
        int antes[N];
        int held;
        int n;
        int ticks_zero;

        rst   = 1'b1;
        pausa = 1'b0;
        acao  = '0;

        // 1: idle decay, ten ticks bring every attribute to 245
        do_reset();
        repeat (41) apply_stimulus(1'b0, 3'b000);
        for (int i = 0; i < N; i++) check_output("decay_10_ticks", ch(i), 245);
        check_output("idle_alarme", alarme, 0);

        // 2: saturation at the top, then gain on a tick cycle
        do_reset();
        apply_stimulus(1'b0, 3'b001);
        check_output("saturacao", ch(ATR_FOME), 255);
        guard = 0;
        while (!(m_v[0] == 10 && m_tick) && guard < 5000) begin
            apply_stimulus(1'b0, 3'b000);
            guard++;
        end
        if (guard >= 5000) check_output("timeout_preload", 0, 1);
        apply_stimulus(1'b0, 3'b001);
        check_output("ganho_no_tick", ch(ATR_FOME), 25);

        // 3: alarm threshold on channel 1
        do_reset();
        guard = 0;
        while (m_v[1] != 63 && guard < 5000) begin
            apply_stimulus(1'b0, 3'b000);
            guard++;
        end
        if (guard >= 5000) check_output("timeout_limiar", 0, 1);
        check_output("valor_63", ch(ATR_FELICIDADE), 63);
        check_output("alarme_63", alarme[ATR_FELICIDADE], 1);
        apply_stimulus(1'b0, 3'b010);
        check_output("valor_79", ch(ATR_FELICIDADE), 79);
        check_output("alarme_79", alarme[ATR_FELICIDADE], 0);

        // 4: pause freezes decay but not actions; resume from held count
        for (int i = 0; i < N; i++) antes[i] = m_v[i];
        repeat (20) apply_stimulus(1'b1, 3'b000);
        for (int i = 0; i < N; i++) check_output("pausa_congela", ch(i), antes[i]);
        apply_stimulus(1'b1, 3'b100);
        check_output("acao_em_pausa", ch(ATR_SONO), (antes[2] + GN > 255) ? 255 : antes[2] + GN);
        held = m_cnt;
        n = 0;
        do begin
            apply_stimulus(1'b0, 3'b000);
            n++;
        end while (!tick && n < 20);
        check_output("retomada", n, TD - held);

        // 5: death after three empty ticks, frozen afterwards, async reset
        do_reset();
        guard      = 0;
        ticks_zero = 0;
        while (!morreu && guard < 3000) begin
            apply_stimulus(1'b0, 3'b000);
            if (tick && ch(ATR_FOME) == 0) ticks_zero++;
            guard++;
        end
        check_output("morreu_set", morreu, 1);
        check_output("ticks_ate_morte", ticks_zero, GR);
        repeat (12) apply_stimulus(1'b0, 3'b111);
        for (int i = 0; i < N; i++) check_output("congelado", ch(i), 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) check_output("reset_assinc_valor", ch(i), 255);
        check_output("reset_assinc_morreu", morreu, 0);
        check_output("reset_assinc_tick", tick, 0);
        @(negedge clk);
        rst  = 1'b0;
        acao = '0;

        // 6: an action clears the empty count; death needs fresh empty ticks
        do_reset();
        cyc = 1;
        wait_empty_ticks(2);
        check_output("vazio_2_vivo", morreu, 0);
        apply_stimulus(1'b0, 3'b001);
        check_output("apos_limpeza", morreu, 0);
        wait_empty_ticks(2);
        check_output("sem_morte_apos_limpeza", morreu, 0);
        wait_empty_ticks(1);
        check_output("morte_nova_contagem", morreu, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
